// File: rtl/scaled_clock_bank.sv
// Bank of independent programmable clock dividers on inclk, each with a run enable,
// a double-buffered half-period divisor and a rising-edge tick strobe.
module scaled_clock_bank #(
    parameter int CHANNELS    = 3,
    parameter int CNT_W       = 28,
    parameter int DEFAULT_DIV = 5000000,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                inclk,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] ena,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [CNT_W-1:0]    cfg_div,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] div_active;
        logic [CNT_W-1:0] div_shadow;
        logic             clk_q;
        logic             tick_q;
        logic             wr_hit;

        // Out-of-range channel indices never match any i, so such writes fall away.
        assign wr_hit = cfg_we && (int'(cfg_ch) == i);

        always_ff @(posedge inclk or negedge reset_n) begin
            if (!reset_n) begin
                count      <= '0;
                clk_q      <= 1'b0;
                tick_q     <= 1'b0;
                div_active <= DIV_RST;
                div_shadow <= DIV_RST;
            end else begin
                if (wr_hit)
                    div_shadow <= cfg_div;

                if (!ena[i]) begin
                    count      <= '0;
                    clk_q      <= 1'b0;
                    tick_q     <= 1'b0;
                    div_active <= div_shadow;
                end else if (count == div_active) begin
                    // Shadow sampled before this edge: a same-cycle write waits one more half-period.
                    count      <= '0;
                    clk_q      <= ~clk_q;
                    tick_q     <= ~clk_q;
                    div_active <= div_shadow;
                end else begin
                    count      <= count + 1'b1;
                    tick_q     <= 1'b0;
                end
            end
        end

        assign clk_out[i] = clk_q;
        assign tick[i]    = tick_q;
    end

endmodule
